dram_user_responder: RTL

DRAM_USER_RESPONDER -- requirements
Module: dram_user_responder

---
 rtl/dram_user_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dram_user_responder.sv
// Behavioural DRAM user-port responder: emulates calibration, then serves
// burst reads/writes against an internal block-RAM backing store.
module dram_user_responder #(
  parameter int DATA_W      = 512,
  parameter int DEPTH_LOG2  = 10,
  parameter int INIT_CYCLES = 64,
  parameter int GAP         = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        D_REQ,
  input  logic [31:0]       D_INITADR,
  input  logic [31:0]       D_ELEM,
  output logic              D_BUSY,
  input  logic [DATA_W-1:0] D_DIN,
  output logic              D_W,
  output logic [DATA_W-1:0] D_DOUT,
  output logic              D_DOUTEN
);

  localparam int OFFS = $clog2(DATA_W / 8);
  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES);
  localparam logic [3:0] GAP_RELOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;

  state_t                  state_q;
  logic [31:0]             init_cnt_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic [31:0]             remain_q;
  logic [3:0]              gap_q;
  logic                    beat_q;
  logic                    d_busy_q;
  logic                    d_w_q;
  logic                    d_douten_q;
  logic [DATA_W-1:0]       d_dout_q;
  logic [DATA_W-1:0]       mem_q [2**DEPTH_LOG2];

  logic req_wr;
  logic req_rd;
  logic last_beat;
  logic addr_unused;

  assign req_wr      = (D_REQ == 2'b10);
  assign req_rd      = (D_REQ == 2'b01);
  assign last_beat   = (remain_q == 32'd1);
  assign addr_unused = ^{D_INITADR[31:OFFS+DEPTH_LOG2], D_INITADR[OFFS-1:0]};

  // Store has no reset so its contents survive RST; a beat under reset is dropped.
  always_ff @(posedge CLK) begin
    if (d_w_q && !RST) begin
      mem_q[addr_q] <= D_DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      gap_q      <= '0;
      beat_q     <= 1'b0;
      d_busy_q   <= 1'b1;
      d_w_q      <= 1'b0;
      d_douten_q <= 1'b0;
      d_dout_q   <= '0;
    end else begin
      d_douten_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q  <= ST_IDLE;
            d_busy_q <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + 32'd1;
          end
        end
        ST_IDLE: begin
          if (req_wr || req_rd) begin
            addr_q   <= D_INITADR[OFFS +: DEPTH_LOG2];
            remain_q <= D_ELEM;
            gap_q    <= '0;
            d_busy_q <= 1'b1;
            if (D_ELEM == 32'd0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= req_wr ? ST_WRITE : ST_READ;
              beat_q  <= 1'b1;
              d_w_q   <= req_wr;
            end
          end
        end
        ST_WRITE, ST_READ: begin
          if (beat_q) begin
            if (state_q == ST_READ) begin
              d_dout_q   <= mem_q[addr_q];
              d_douten_q <= 1'b1;
            end
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 32'd1;
            if (last_beat) begin
              beat_q <= 1'b0;
              d_w_q  <= 1'b0;
              if (state_q == ST_WRITE) begin
                state_q  <= ST_IDLE;
                d_busy_q <= 1'b0;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else if (GAP != 0) begin
              beat_q <= 1'b0;
              d_w_q  <= 1'b0;
              gap_q  <= GAP_RELOAD;
            end
          end else if (gap_q == 4'd0) begin
            beat_q <= 1'b1;
            d_w_q  <= (state_q == ST_WRITE);
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        ST_DRAIN: begin
          // Final read data is on the port this cycle; release busy after it.
          state_q  <= ST_IDLE;
          d_busy_q <= 1'b0;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign D_BUSY   = d_busy_q;
  assign D_W      = d_w_q;
  assign D_DOUT   = d_dout_q;
  assign D_DOUTEN = d_douten_q;

endmodule
